// File: rtl/snitch_icache_pkg.sv
// Shared types and width helpers for the snitch icache refill path.
package snitch_icache_pkg;

   typedef enum logic [1:0] {IDLE, REQ, BEAT, WRITE} refill_state_e;

   // Index width that stays at least one bit even for a single entry.
   function automatic int unsigned min_one_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snitch_icache_refill_victim.sv
// Victim set selection: round-robin pointer, or an 8-bit LFSR when
// SNITCH_ICACHE_REFILL_LFSR_EN is defined.
module snitch_icache_refill_victim #(
   parameter int unsigned SET_COUNT = 2,
   parameter int unsigned SET_ALIGN = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 advance_i,
   input  logic                 latch_i,
   output logic [SET_ALIGN-1:0] set_o
);

`ifdef SNITCH_ICACHE_REFILL_LFSR_EN
   logic [7:0]           lfsr_q;
   logic [SET_ALIGN-1:0] set_q;
   logic                 unused_ctrl;

   assign unused_ctrl = flush_i | advance_i;

   // Fibonacci taps 8,6,5,4; free-running, only the reset reseeds it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= 8'hA5;
         set_q  <= '0;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         if (latch_i) set_q <= (SET_COUNT > 1) ? lfsr_q[SET_ALIGN-1:0] : '0;
      end
   end

   assign set_o = set_q;
`else
   logic [SET_ALIGN-1:0] ptr_q;
   logic                 unused_latch;

   assign unused_latch = latch_i;

   // Flush takes priority over an advance landing in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (flush_i) begin
         ptr_q <= '0;
      end else if (advance_i) begin
         if (ptr_q == SET_ALIGN'(SET_COUNT - 1)) ptr_q <= '0;
         else                                    ptr_q <= ptr_q + SET_ALIGN'(1);
      end
   end

   assign set_o = ptr_q;
`endif

endmodule

// File: rtl/snitch_icache_refill_writer.sv
// Icache refill engine: one outstanding miss, beat assembly, lookup write.
// Victim policy switches to an LFSR with SNITCH_ICACHE_REFILL_LFSR_EN.
module snitch_icache_refill_writer
   import snitch_icache_pkg::*;
#(
   parameter int unsigned FETCH_AW   = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned LINE_COUNT = 64,
   parameter int unsigned SET_COUNT  = 2,
   parameter int unsigned FILL_DW    = 64,
   localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8),
   localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
   localparam int unsigned SET_ALIGN   = min_one_clog2(SET_COUNT),
   localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic [FETCH_AW-1:0]    miss_addr_i,
   input  logic [ID_WIDTH-1:0]    miss_id_i,
   input  logic                   miss_valid_i,
   output logic                   miss_ready_o,
   output logic [FETCH_AW-1:0]    refill_req_addr_o,
   output logic                   refill_req_valid_o,
   input  logic                   refill_req_ready_i,
   input  logic [FILL_DW-1:0]     refill_rsp_data_i,
   input  logic                   refill_rsp_error_i,
   input  logic                   refill_rsp_valid_i,
   output logic                   refill_rsp_ready_o,
   output logic [COUNT_ALIGN-1:0] write_addr_o,
   output logic [SET_ALIGN-1:0]   write_set_o,
   output logic [LINE_WIDTH-1:0]  write_data_o,
   output logic [TAG_WIDTH-1:0]   write_tag_o,
   output logic                   write_error_o,
   output logic                   write_valid_o,
   input  logic                   write_ready_i,
   output logic [ID_WIDTH-1:0]    done_id_o,
   output logic                   done_valid_o
);

   localparam int unsigned BEATS  = LINE_WIDTH / FILL_DW;
   localparam int unsigned CNT_W  = min_one_clog2(BEATS);
   localparam int unsigned LADDR_W = FETCH_AW - LINE_ALIGN;

   refill_state_e         state_q;
   logic [LADDR_W-1:0]    addr_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [LINE_WIDTH-1:0] buf_q;
   logic                  err_q;
   logic                  done_q;
   logic                  last_beat;
   logic                  write_hs;
   logic [LINE_ALIGN-1:0] unused_offset;

   assign unused_offset = miss_addr_i[LINE_ALIGN-1:0];
   assign last_beat     = (cnt_q == CNT_W'(BEATS - 1));
   assign write_hs      = (state_q == WRITE) && write_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (miss_valid_i) begin
               addr_q  <= miss_addr_i[FETCH_AW-1:LINE_ALIGN];
               id_q    <= miss_id_i;
               state_q <= REQ;
            end
            REQ: if (refill_req_ready_i) begin
               cnt_q   <= '0;
               state_q <= BEAT;
            end
            BEAT: if (refill_rsp_valid_i) begin
               buf_q[cnt_q*FILL_DW +: FILL_DW] <= refill_rsp_data_i;
               err_q <= err_q | refill_rsp_error_i;
               if (last_beat) state_q <= WRITE;
               else           cnt_q   <= cnt_q + CNT_W'(1);
            end
            // The done pulse trails the handshake so the SRAM write is visible.
            WRITE: if (write_ready_i) begin
               err_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   snitch_icache_refill_victim #(
      .SET_COUNT (SET_COUNT),
      .SET_ALIGN (SET_ALIGN)
   ) i_victim (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .advance_i (write_hs),
      .latch_i   ((state_q == BEAT) && refill_rsp_valid_i && last_beat),
      .set_o     (write_set_o)
   );

   assign miss_ready_o       = (state_q == IDLE);
   assign refill_req_valid_o = (state_q == REQ);
   assign refill_rsp_ready_o = (state_q == BEAT);
   assign write_valid_o      = (state_q == WRITE);
   assign refill_req_addr_o  = {addr_q, {LINE_ALIGN{1'b0}}};
   assign write_addr_o       = addr_q[COUNT_ALIGN-1:0];
   assign write_tag_o        = addr_q[LADDR_W-1 -: TAG_WIDTH];
   assign write_data_o       = buf_q;
   assign write_error_o      = err_q;
   assign done_id_o          = id_q;
   assign done_valid_o       = done_q;

endmodule
